// File: rtl/elbeth_dmem_responder_pkg.sv
// Shared definitions for the ELBETH data-memory responder.
//   - size codes (one-hot, dmem_rw[2:0]) and the write-enable bit index
//   - FSM state encoding
//   - captured request record
package elbeth_dmem_responder_pkg;

  localparam logic [2:0] DMEM_SZ_B   = 3'b001;
  localparam logic [2:0] DMEM_SZ_H   = 3'b010;
  localparam logic [2:0] DMEM_SZ_W   = 3'b100;
  localparam int         DMEM_WE_BIT = 3;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_WAIT = 2'd1,
    DMEM_ST_DONE = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/elbeth_dmem_responder_lane_align.sv
// elbeth_dmem_lane_align: purely combinational byte-lane steering.
//   addr_lo   in  2  : byte offset within the word
//   size      in  3  : one-hot access size (byte/half/word)
//   sign      in  1  : sign-extend sub-word reads
//   wdata     in  32 : LSB-justified store data
//   rword     in  32 : raw word read from the array
//   wmask     out 4  : byte lanes written
//   wdata_sh  out 32 : store data replicated onto its lanes
//   rdata_ext out 32 : selected lane(s), extended
//   misaligned out 1 : address not aligned to the size (0 for non-one-hot sizes)
module elbeth_dmem_lane_align
  import elbeth_dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane select by shifting the word down; only the low bits are used.
  assign rshift = rword >> {addr_lo, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    wmask      = 4'b0000;
    wdata_sh   = 32'h0;
    rdata_ext  = 32'h0;
    misaligned = 1'b0;
    case (size)
      DMEM_SZ_B: begin
        wmask     = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{sign & rbyte[7]}}, rbyte};
      end
      DMEM_SZ_H: begin
        wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh   = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign & rhalf[15]}}, rhalf};
        misaligned = addr_lo[0];
      end
      DMEM_SZ_W: begin
        wmask      = 4'b1111;
        wdata_sh   = wdata;
        rdata_ext  = rword;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/elbeth_dmem_responder.sv
// elbeth_dmem_responder: slave end of the dmem_en/dmem_rw/dmem_ready handshake.
// Latches one request, waits WAIT_CYCLES, then performs a lane-aligned write or
// an extended read on the internal word array and pulses dmem_ready for one cycle.
//   clk, rst (sync, active high)
//   dmem_en, dmem_rw[3:0], dmem_sign, dmem_addr[31:0], dmem_wdata[31:0] : request
//   dmem_ready, dmem_rdata[31:0], dmem_except_misaligned, dmem_except_illegal : response
module elbeth_dmem_responder
  import elbeth_dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_en,
  input  logic [3:0]  dmem_rw,
  input  logic        dmem_sign,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_except_misaligned,
  output logic        dmem_except_illegal
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_e state;
  logic [3:0]  cnt;
  dmem_req_t   req_q, req_in, req_cur;

  logic [31:0] offset;
  logic [IW-1:0] word_idx;
  logic        illegal, misaligned, mis_raw;
  logic        enter_done, commit;
  logic [3:0]  wmask;
  logic [31:0] wdata_sh, rdata_ext, rword;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_in = '{we:    dmem_rw[DMEM_WE_BIT],
                    size:  dmem_rw[2:0],
                    sign:  dmem_sign,
                    addr:  dmem_addr,
                    wdata: dmem_wdata};

  // With zero wait states the access completes on the capture edge itself, so
  // the live request is used while IDLE; otherwise the captured copy is used and
  // any change on the inputs during WAIT is ignored.
  assign req_cur = (state == DMEM_ST_IDLE) ? req_in : req_q;

  // Unsigned wrap makes addresses below ADDR_BASE land out of range too.
  assign offset   = req_cur.addr - ADDR_BASE;
  assign word_idx = offset[IW+1:2];
  assign illegal  = ((offset >> 2) >= 32'(DEPTH_WORDS)) || !$onehot(req_cur.size);
  assign misaligned = mis_raw & ~illegal;

  // Out-of-range index wraps inside the array; the value is never used then.
  assign rword = mem[word_idx];

  elbeth_dmem_lane_align u_align (
    .addr_lo    (req_cur.addr[1:0]),
    .size       (req_cur.size),
    .sign       (req_cur.sign),
    .wdata      (req_cur.wdata),
    .rword      (rword),
    .wmask      (wmask),
    .wdata_sh   (wdata_sh),
    .rdata_ext  (rdata_ext),
    .misaligned (mis_raw)
  );

  // The edge that moves the FSM into DONE; reset on the same edge cancels it.
  assign enter_done = !rst && dmem_en &&
                      (((state == DMEM_ST_IDLE) && (WAIT_CYCLES == 0)) ||
                       ((state == DMEM_ST_WAIT) && (cnt == 4'd1)));
  assign commit = enter_done && req_cur.we && !illegal && !misaligned;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= DMEM_ST_IDLE;
      cnt                    <= 4'd0;
      req_q                  <= '0;
      dmem_ready             <= 1'b0;
      dmem_rdata             <= 32'h0;
      dmem_except_misaligned <= 1'b0;
      dmem_except_illegal    <= 1'b0;
    end else begin
      dmem_ready             <= 1'b0;
      dmem_rdata             <= 32'h0;
      dmem_except_misaligned <= 1'b0;
      dmem_except_illegal    <= 1'b0;
      if (enter_done) begin
        dmem_ready             <= 1'b1;
        dmem_rdata             <= (req_cur.we || illegal || misaligned) ? 32'h0 : rdata_ext;
        dmem_except_misaligned <= misaligned;
        dmem_except_illegal    <= illegal;
      end
      case (state)
        DMEM_ST_IDLE: begin
          if (dmem_en) begin
            req_q <= req_in;
            cnt   <= 4'(WAIT_CYCLES);
            state <= (WAIT_CYCLES > 0) ? DMEM_ST_WAIT : DMEM_ST_DONE;
          end
        end
        DMEM_ST_WAIT: begin
          if (!dmem_en) begin
            // Requester flushed the access: drop it without touching memory.
            state <= DMEM_ST_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= DMEM_ST_DONE;
          end
        end
        DMEM_ST_DONE: state <= DMEM_ST_IDLE;
        default:      state <= DMEM_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_dmem_responder.sv
module tb_elbeth_dmem_responder;

  localparam logic [31:0] BASE1 = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        en  [2];
  logic [3:0]  rw  [2];
  logic        sg  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic        rdy [2];
  logic [31:0] rd  [2];
  logic        mis [2];
  logic        ill [2];

  always #5 clk = ~clk;

  elbeth_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dut0 (
    .clk(clk), .rst(rst[0]), .dmem_en(en[0]), .dmem_rw(rw[0]), .dmem_sign(sg[0]),
    .dmem_addr(ad[0]), .dmem_wdata(wd[0]), .dmem_ready(rdy[0]), .dmem_rdata(rd[0]),
    .dmem_except_misaligned(mis[0]), .dmem_except_illegal(ill[0]));

  elbeth_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .ADDR_BASE(BASE1)) dut3 (
    .clk(clk), .rst(rst[1]), .dmem_en(en[1]), .dmem_rw(rw[1]), .dmem_sign(sg[1]),
    .dmem_addr(ad[1]), .dmem_wdata(wd[1]), .dmem_ready(rdy[1]), .dmem_rdata(rd[1]),
    .dmem_except_misaligned(mis[1]), .dmem_except_illegal(ill[1]));

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mdl [bit [32:0]];
  int nchk = 0, npass = 0;
  int cyc = 0;
  int rdy_cnt [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Byte-addressed little-endian reference of the spec's rules.
  function automatic void model(input int s, input logic [3:0] r, input logic sgn,
                                input logic [31:0] a, input logic [31:0] w,
                                output logic [31:0] erd, output logic emis, output logic eill);
    int n;
    logic [31:0] base, depth, off;
    base  = (s == 1) ? BASE1 : 32'h0;
    depth = (s == 1) ? 32'd256 : 32'd1024;
    case (r[2:0])
      3'b001: n = 1;
      3'b010: n = 2;
      3'b100: n = 4;
      default: n = 0;
    endcase
    off  = a - base;
    eill = (n == 0) || ((off / 4) >= depth);
    emis = !eill && ((a % n) != 0);
    erd  = 32'h0;
    if (!eill && !emis) begin
      if (r[3]) begin
        for (int i = 0; i < n; i++) mdl[{s[0], a + i}] = w[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) erd |= 32'(mdl[{s[0], a + i}]) << (8*i);
        if (sgn && n < 4 && erd[8*n-1]) erd |= 32'hFFFF_FFFF << (8*n);
      end
    end
  endfunction

  task automatic req(input int s, input logic [3:0] r, input logic sgn,
                     input logic [31:0] a, input logic [31:0] w, output logic [31:0] got);
    exp_t e;
    int n;
    model(s, r, sgn, a, w, e.rd, e.mis, e.ill);
    @(negedge clk);
    e.cyc = cyc + 1 + ((s == 1) ? 3 : 0);
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    en[s] = 1'b1; rw[s] = r; sg[s] = sgn; ad[s] = a; wd[s] = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[s] && n < 40);
    chk("ready_seen", 32'(rdy[s]), 32'd1);
    got = rd[s];
    en[s] = 1'b0;
  endtask

  // mode 0: drop dmem_en two cycles into WAIT; mode 1: reset on the would-be DONE edge.
  task automatic abort_req(input int s, input int mode, input logic [31:0] a, input logic [31:0] w);
    int c0;
    @(negedge clk);
    c0 = rdy_cnt[s];
    en[s] = 1'b1; rw[s] = 4'b1100; sg[s] = 1'b0; ad[s] = a; wd[s] = w;
    if (mode == 0) begin
      repeat (2) @(negedge clk);
      en[s] = 1'b0;
    end else begin
      repeat (3) @(negedge clk);
      rst[s] = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(rdy[s]), 32'd0);
      chk("rst_rdata", rd[s], 32'h0);
      chk("rst_flags", {30'd0, mis[s], ill[s]}, 32'd0);
      rst[s] = 1'b0;
      en[s] = 1'b0;
    end
    repeat (8) @(negedge clk);
    chk(mode == 0 ? "abort_no_ready" : "rst_no_ready", 32'(rdy_cnt[s] - c0), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents dmem_ready.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rdy[k] === 1'b1) begin
        exp_t e;
        logic have;
        rdy_cnt[k]++;
        have = 1'b0;
        if (k == 0) begin
          if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
          if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        end
        if (!have) begin
          chk("unexpected_ready", 32'(k), 32'hFFFF_FFFF);
        end else begin
          chk("rdata", rd[k], e.rd);
          chk("misaligned", 32'(mis[k]), 32'(e.mis));
          chk("illegal", 32'(ill[k]), 32'(e.ill));
          chk("ready_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic random_ops(input int s, input int count);
    logic [31:0] base, a, w, got;
    logic [3:0]  r;
    logic [2:0]  bad [5];
    bad[0] = 3'b000; bad[1] = 3'b011; bad[2] = 3'b101; bad[3] = 3'b110; bad[4] = 3'b111;
    base = (s == 1) ? BASE1 : 32'h0;
    for (int i = 0; i < count; i++) begin
      case ($urandom_range(0, 9))
        0:       r[2:0] = bad[$urandom_range(0, 4)];
        1, 2, 3: r[2:0] = 3'b001;
        4, 5, 6: r[2:0] = 3'b010;
        default: r[2:0] = 3'b100;
      endcase
      r[3] = 1'($urandom_range(0, 1));
      a = base + 32'($urandom_range(0, 63));
      case ($urandom_range(0, 19))
        0: a = base + ((s == 1) ? 32'd1024 : 32'd4096) + 32'($urandom_range(0, 7));
        1: a = base - 32'd4;
        default: ;
      endcase
      w = $urandom;
      req(s, r, 1'($urandom_range(0, 1)), a, w, got);
    end
  endtask

  logic [31:0] got;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; en[k] = 1'b0; rw[k] = 4'h0; sg[k] = 1'b0; ad[k] = 32'h0; wd[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", 32'(rdy[k]), 32'd0);
      chk("reset_rdata", rd[k], 32'h0);
      chk("reset_mis", 32'(mis[k]), 32'd0);
      chk("reset_ill", 32'(ill[k]), 32'd0);
    end

    // Known contents for the test window of each array.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++)
        req(k, 4'b1100, 1'b0, ((k == 1) ? BASE1 : 32'h0) + 32'(4*i), $urandom, got);

    // Directed plan, zero wait states.
    req(0, 4'b1100, 1'b0, 32'h10, 32'hDEAD_BEEF, got);
    req(0, 4'b0100, 1'b0, 32'h10, 32'h0, got);       chk("plan_word", got, 32'hDEAD_BEEF);
    req(0, 4'b1001, 1'b0, 32'h13, 32'h0000_0080, got);
    req(0, 4'b0100, 1'b0, 32'h10, 32'h0, got);       chk("plan_byte_word", got, 32'h80AD_BEEF);
    req(0, 4'b0001, 1'b1, 32'h13, 32'h0, got);       chk("plan_sbyte", got, 32'hFFFF_FF80);
    req(0, 4'b0001, 1'b0, 32'h13, 32'h0, got);       chk("plan_ubyte", got, 32'h0000_0080);
    req(0, 4'b1010, 1'b0, 32'h22, 32'h0000_8001, got);
    req(0, 4'b0010, 1'b1, 32'h22, 32'h0, got);       chk("plan_shalf", got, 32'hFFFF_8001);
    req(0, 4'b0010, 1'b0, 32'h22, 32'h0, got);       chk("plan_uhalf", got, 32'h0000_8001);
    req(0, 4'b1100, 1'b0, 32'h11, 32'h1234_5678, got);
    req(0, 4'b0100, 1'b0, 32'h10, 32'h0, got);       chk("plan_mis_nowrite", got, 32'h80AD_BEEF);
    req(0, 4'b0100, 1'b0, 32'h1000, 32'h0, got);     chk("plan_ill_rdata", got, 32'h0);
    req(0, 4'b0011, 1'b0, 32'h10, 32'h0, got);

    // Wait-state instance: timing, flush and reset.
    req(1, 4'b1100, 1'b0, BASE1 + 32'h8, 32'hCAFE_F00D, got);
    abort_req(1, 0, BASE1 + 32'h8, 32'h1111_1111);
    req(1, 4'b0100, 1'b0, BASE1 + 32'h8, 32'h0, got); chk("abort_unchanged", got, 32'hCAFE_F00D);
    abort_req(1, 1, BASE1 + 32'h8, 32'h2222_2222);
    req(1, 4'b0100, 1'b0, BASE1 + 32'h8, 32'h0, got); chk("rst_unchanged", got, 32'hCAFE_F00D);
    req(1, 4'b0100, 1'b0, BASE1 + 32'd1024, 32'h0, got);

    random_ops(0, 150);
    random_ops(1, 80);

    repeat (5) @(negedge clk);
    chk("sb_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
